// File: rtl/sram_mem_ctrl_if.sv
// rtl/sram_mem_ctrl_if.sv - pipeline and SRAM bus bundle for sram_mem_ctrl
interface sram_mem_ctrl_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic                   freeze;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic                   sram_dq_oe;
  logic [15:0]            sram_dq_in;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  // Pipeline plus SRAM device side
  modport master (
    output mem_read, mem_write, address, write_data, sram_dq_in,
    input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n
  );

  // Controller side
  modport slave (
    input  mem_read, mem_write, address, write_data, sram_dq_in,
    output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit word access as two 16-bit SRAM halfwords; SRAM_CTRL_STALL_CNT_EN adds stall_count
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SRAM_CTRL_STALL_CNT_EN
  output logic [31:0] stall_count,
`endif
  sram_mem_ctrl_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             op_wr_q, op_wr_d;
  logic [15:0]      rd_lo_q, rd_lo_d;
  logic [31:0]      read_data_q, read_data_d;

  logic             phase_last;
  logic             half;
  logic [31:0]      eff;
  logic             ready_w;
  logic             freeze_w;
  logic             unused_eff;

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      rd_lo_q     <= rd_lo_d;
      read_data_q <= read_data_d;
    end
  end

  // Next state: latch in IDLE, hold each half for WAIT_CYCLES, capture read data on the last cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    phase_last  = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (bus.mem_write || bus.mem_read) begin
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          op_wr_d = bus.mem_write;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_last) begin
          if (!op_wr_q) rd_lo_d = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (phase_last) begin
          if (!op_wr_q) read_data_d = {bus.sram_dq_in, rd_lo_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM bus decoded from state and latched fields; idle outside LOW/HIGH
  always_comb begin
    half            = (state_q == HIGH);
    eff             = addr_q - MEM_BASE;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    bus.sram_oe_n   = 1'b1;
    if (state_q == LOW || state_q == HIGH) begin
      bus.sram_addr = {eff[SRAM_ADDR_W:2], half};
      if (op_wr_q) begin
        bus.sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
        bus.sram_dq_oe  = 1'b1;
        bus.sram_we_n   = 1'b0;
      end else begin
        bus.sram_oe_n = 1'b0;
      end
    end
  end

  // Byte-offset bits and bits above the SRAM range play no part in the halfword address
  assign unused_eff    = &{1'b0, eff[31:SRAM_ADDR_W+1], eff[1:0]};

  assign ready_w       = (state_q == DONE);
  assign freeze_w      = (bus.mem_read | bus.mem_write) & ~ready_w;
  assign bus.ready     = ready_w;
  assign bus.freeze    = freeze_w;
  assign bus.read_data = read_data_q;

`ifdef SRAM_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, sticking at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_w && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
